// File: rtl/binary_multiplier.sv
// -----------------------------------------------------------------------------
// binary_multiplier
//
// Sequential unsigned shift-and-add multiplier. A start request in IDLE
// captures both operands. One multiplier bit is retired per clock for WIDTH
// clocks. A final COMPLETE cycle then registers the 2*WIDTH-bit product and
// pulses done for one cycle. Latency is fixed and independent of the data.
//
// Ports:
//   clk               sole clock, rising edge
//   reset             synchronous, active-high reset
//   mul_en            start request, honoured only in IDLE
//   g_multiplicand_Q  operand A, captured on the accepting edge
//   g_multiplier_Q    operand B, captured on the accepting edge
//   product           registered A*B, held until the next completion or reset
//   done              registered one-cycle completion pulse
//   busy              high whenever the FSM is not in IDLE
//
// Handshake: the request is a level sampled on a clock edge while busy is
// low. A request seen while busy is high is ignored and is not queued. Each
// accepted request produces exactly one done pulse WIDTH+1 edges later,
// unless reset intervenes.
// -----------------------------------------------------------------------------
module binary_multiplier #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 mul_en,
    input  logic [WIDTH-1:0]     g_multiplicand_Q,
    input  logic [WIDTH-1:0]     g_multiplier_Q,
    output logic [2*WIDTH-1:0]   product,
    output logic                 done,
    output logic                 busy
);

    localparam int CW = $clog2(WIDTH) + 1;

    localparam logic [1:0] S_IDLE     = 2'b00;
    localparam logic [1:0] S_RUN      = 2'b01;
    localparam logic [1:0] S_COMPLETE = 2'b11;

    // Count value seen during the final RUN iteration.
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    logic [1:0]           state_q,   state_d;
    logic [2*WIDTH-1:0]   mcand_q,   mcand_d;
    logic [WIDTH-1:0]     mplr_q,    mplr_d;
    logic [2*WIDTH-1:0]   acc_q,     acc_d;
    logic [CW-1:0]        count_q,   count_d;
    logic [2*WIDTH-1:0]   product_q, product_d;
    logic                 done_q,    done_d;

    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        mplr_d    = mplr_q;
        acc_d     = acc_q;
        count_d   = count_q;
        product_d = product_q;
        done_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (mul_en) begin
                    mcand_d = {{WIDTH{1'b0}}, g_multiplicand_Q};
                    mplr_d  = g_multiplier_Q;
                    acc_d   = '0;
                    count_d = '0;
                    state_d = S_RUN;
                end
            end

            S_RUN: begin
                // The accumulator is 2*WIDTH bits wide, so this add cannot overflow.
                if (mplr_q[0]) begin
                    acc_d = acc_q + mcand_q;
                end
                mcand_d = mcand_q << 1;
                mplr_d  = mplr_q >> 1;
                count_d = count_q + CW'(1);
                // The run always lasts WIDTH iterations. It does not stop
                // early when mplr becomes zero.
                if (count_q == LAST_ITER) begin
                    state_d = S_COMPLETE;
                end
            end

            S_COMPLETE: begin
                product_d = acc_q;
                done_d    = 1'b1;
                state_d   = S_IDLE;
            end

            // 2'b10 is unreachable. Fall back to IDLE.
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            mcand_q   <= '0;
            mplr_q    <= '0;
            acc_q     <= '0;
            count_q   <= '0;
            product_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            mplr_q    <= mplr_d;
            acc_q     <= acc_d;
            count_q   <= count_d;
            product_q <= product_d;
            done_q    <= done_d;
        end
    end

    assign product = product_q;
    assign done    = done_q;
    assign busy    = (state_q != S_IDLE);

endmodule

// File: tb/tb_binary_multiplier.sv
// -----------------------------------------------------------------------------
// tb_binary_multiplier
//
// Scoreboard bench for binary_multiplier. Each accepted start pushes its
// expected product (plain 64-bit multiply) and expected completion cycle.
// The monitor pops an entry on every done pulse. On all other cycles it
// checks that product holds its last value.
// -----------------------------------------------------------------------------
module tb_binary_multiplier;

    localparam int W   = 32;
    localparam int LAT = W + 1;   // edges from acceptance to visible done

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             mul_en = 1'b0;
    logic [W-1:0]     op_a = '0;
    logic [W-1:0]     op_b = '0;
    logic [2*W-1:0]   product;
    logic             done;
    logic             busy;

    int unsigned      cyc = 0;
    int               compared = 0;
    int               mismatched = 0;

    logic [2*W-1:0]   exp_q[$];
    int unsigned      exp_cyc_q[$];
    logic [2*W-1:0]   model_prod = '0;
    bit               mon_en = 1'b0;

    logic [2*W-1:0]   mon_e;
    int unsigned      mon_ec;

    binary_multiplier #(.WIDTH(W)) dut (
        .clk              (clk),
        .reset            (reset),
        .mul_en           (mul_en),
        .g_multiplicand_Q (op_a),
        .g_multiplier_Q   (op_b),
        .product          (product),
        .done             (done),
        .busy             (busy)
    );

    // ---------------------------------------------------------------- clock
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ------------------------------------------------------------ compare
    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h required %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // -------------------------------------------------------------- monitor
    always @(negedge clk) begin
        if (mon_en && !reset) begin
            if (done) begin
                if (exp_q.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL spurious_done: done=1 product=%h at cycle %0d, required no pending result",
                             product, cyc);
                end else begin
                    mon_e  = exp_q.pop_front();
                    mon_ec = exp_cyc_q.pop_front();
                    check64("product", product, mon_e);
                    check64("done_latency", 64'(cyc), 64'(mon_ec));
                    model_prod = mon_e;
                end
            end else begin
                check64("product_hold", product, model_prod);
            end
        end
    end

    // -------------------------------------------------------------- drivers
    // Called at posedge+#1. Asserts reset for one edge. mul_en may be
    // driven high at the same time to check that reset wins.
    task automatic do_reset(input bit with_en);
        reset  = 1'b1;
        mul_en = with_en;
        op_a   = $urandom();
        op_b   = $urandom();
        exp_q.delete();
        exp_cyc_q.delete();
        model_prod = '0;
        @(posedge clk); #1;
        reset  = 1'b0;
        mul_en = 1'b0;
        mon_en = 1'b1;
        check64("reset_busy",    64'(busy), 64'd0);
        check64("reset_done",    64'(done), 64'd0);
        check64("reset_product", product,   64'd0);
    endtask

    // Waits for IDLE, then presents a request that is accepted on the next
    // edge. Records the expectation and returns the acceptance cycle.
    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b,
                            input bit hold, output int unsigned acc_cyc);
        int n;
        n = 0;
        while (busy && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (busy) begin
            compared++;
            mismatched++;
            $display("FAIL start_timeout: busy=1 after %0d cycles, required 0", n);
        end
        op_a   = a;
        op_b   = b;
        mul_en = 1'b1;
        @(posedge clk); #1;
        acc_cyc = cyc;
        exp_q.push_back(64'(a) * 64'(b));
        exp_cyc_q.push_back(cyc + LAT);
        if (!hold) mul_en = 1'b0;
        check64("busy_after_accept", 64'(busy), 64'd1);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (busy) begin
            compared++;
            mismatched++;
            $display("FAIL idle_timeout: busy=1 after %0d cycles, required 0", n);
        end
        repeat (2) begin
            @(posedge clk); #1;
        end
    endtask

    function automatic logic [W-1:0] pick_operand();
        case ($urandom_range(0, 4))
            0:       return '0;
            1:       return '1;
            2:       return W'(1) << $urandom_range(0, W - 1);
            default: return $urandom();
        endcase
    endfunction

    // ------------------------------------------------------------- stimulus
    initial begin
        int unsigned c1, c2, c3;
        int n;

        reset = 1'b1;
        @(posedge clk); #1;
        do_reset(1'b0);

        // 3*5: busy width, done timing and done width.
        start_op(32'd3, 32'd5, 1'b0, c1);
        n = 0;
        while (busy && n < 100) begin
            n++;
            @(posedge clk); #1;
        end
        check64("busy_cycles", 64'(n), 64'(LAT));
        check64("done_rise", 64'(done), 64'd1);
        @(posedge clk); #1;
        check64("done_width", 64'(done), 64'd0);

        // Full-scale operands, zero operand and a single high bit.
        start_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, c1);
        wait_idle();
        start_op(32'h0, 32'h1234_5678, 1'b0, c1);
        wait_idle();
        start_op(32'h8000_0000, 32'd2, 1'b0, c1);
        wait_idle();

        // 7*9 with mul_en and the operands changing randomly every cycle
        // through RUN and COMPLETE.
        start_op(32'd7, 32'd9, 1'b0, c1);
        repeat (32) begin
            mul_en = 1'($urandom_range(0, 1));
            op_a = $urandom();
            op_b = $urandom();
            @(posedge clk); #1;
        end
        mul_en = 1'($urandom_range(0, 1));
        op_a = $urandom();
        op_b = $urandom();
        @(posedge clk); #1;
        mul_en = 1'b0;
        wait_idle();
        repeat (5) begin
            @(posedge clk); #1;
        end

        // Reset applied on the 10th RUN edge drops the operation.
        start_op(32'd100, 32'd200, 1'b0, c1);
        repeat (9) begin
            @(posedge clk); #1;
        end
        do_reset(1'b0);
        repeat (40) begin
            @(posedge clk); #1;
        end
        start_op(32'd6, 32'd7, 1'b0, c1);
        wait_idle();

        // A start requested together with reset is dropped.
        do_reset(1'b1);
        repeat (3) begin
            @(posedge clk); #1;
        end
        check64("reset_drops_start", 64'(busy), 64'd0);

        // Back-to-back starts with mul_en held high.
        start_op(32'd2, 32'd3, 1'b1, c1);
        start_op(32'd4, 32'd5, 1'b1, c2);
        start_op(32'd6, 32'd7, 1'b0, c3);
        check64("issue_period_1", 64'(c2 - c1), 64'(W + 2));
        check64("issue_period_2", 64'(c3 - c2), 64'(W + 2));
        wait_idle();

        // Random operands with random idle gaps.
        for (int i = 0; i < 25; i++) begin
            start_op(pick_operand(), pick_operand(), 1'b0, c1);
            wait_idle();
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk); #1;
            end
        end

        repeat (5) begin
            @(posedge clk); #1;
        end
        check64("results_outstanding", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    // Global time limit so the run can never hang.
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        mismatched++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/binary_multiplier.md
# binary_multiplier

Sequential unsigned shift-and-add multiplier, the forward counterpart of the sequential restoring divider in the arithmetic datapath. It accepts two WIDTH-bit operands on a single-cycle enable and retires one multiplier bit per clock. It then presents a 2·WIDTH-bit product with a one-cycle `done` pulse. It feeds the divider path and its bench: the product of a quotient and a divisor is the dividend the divider consumes.

## Interface
- `WIDTH`, 32, operand width in bits; product is 2·WIDTH bits.
- `clk`  input  1  sole clock; all state updates on the rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `mul_en`  input  1  start request; sampled only in IDLE.
- `g_multiplicand_Q`  input  WIDTH  operand A; sampled on the edge that accepts `mul_en`.
- `g_multiplier_Q`  input  WIDTH  operand B; sampled on the same edge.
- `product`  output  2·WIDTH  registered A·B; holds its value until the next completion.
- `done`  output  1  registered one-cycle completion pulse.
- `busy`  output  1  high whenever state ≠ IDLE; decoded from the state register.

## Operation
- States: IDLE (2'b00), RUN (2'b01), COMPLETE (2'b11). Encoding 2'b10 is unreachable and must recover to IDLE on the next edge.
- Internal registers:
  - `mcand`: 2·WIDTH bits, shifts left.
  - `mplr`: WIDTH bits, shifts right.
  - `acc`: 2·WIDTH bits.
  - `count`: clog2(WIDTH)+1 bits.
- IDLE:
  - `done` = 0.
  - If `mul_en` = 1: `mcand` ← zero-extended A, `mplr` ← B, `acc` ← 0, `count` ← 0, go to RUN.
  - Otherwise remain in IDLE and leave all internal registers unchanged.
- RUN, each cycle:
  - If `mplr[0]`: `acc` ← `acc` + `mcand` (2·WIDTH-bit add, cannot overflow).
  - `mcand` ← `mcand` << 1, `mplr` ← `mplr` >> 1, `count` ← `count` + 1.
  - When `count` = WIDTH−1 (the last iteration), next state is COMPLETE.
- COMPLETE: `product` ← `acc`, `done` ← 1, next state IDLE.
- Latency is fixed and does not depend on the data. Zero operands and `mplr` emptying early do not shorten the run.
- `mul_en` and operand changes while in RUN or COMPLETE are ignored. They are neither queued nor latched.
- Arithmetic is unsigned only. The result is exact for all 2^(2·WIDTH) operand pairs.

## Timing
- Reset (synchronous, edge with `reset` = 1) sets:
  - state = IDLE, `product` = 0, `done` = 0, `busy` = 0.
  - `acc`, `mcand`, `mplr`, `count` = 0.
- Reset takes precedence over every other condition at any state, including mid-RUN and COMPLETE. An in-flight operation is discarded with no `done` pulse, and `product` returns to 0.
- Accept edge E0 (IDLE, `mul_en` = 1): `busy` rises after E0.
- RUN iterations occur on edges E1..E_WIDTH. State becomes COMPLETE after E_WIDTH.
- On edge E_WIDTH+1: `product` is valid and `done` = 1 for exactly one cycle. State returns to IDLE and `busy` falls.
- `done` falls on E_WIDTH+2. With WIDTH = 32, `done` is high in the cycle following the 33rd edge after acceptance.
- Back-to-back operation: `mul_en` held high is accepted again at E_WIDTH+2, the same edge on which `done` falls. Minimum issue period is WIDTH+2 cycles.
- `product` is stable from E_WIDTH+1 until the next completion or reset. A new start does not disturb it.
- `mul_en` asserted simultaneously with `reset`: reset wins and the request is dropped.

## Test plan
- Reset, then A=3, B=5, `mul_en` pulsed one cycle -> `busy` high for 33 cycles. `done` rises exactly 33 edges after acceptance with `product` = 64'd15. `done` lasts one cycle.
- A = B = 32'hFFFF_FFFF -> `product` = 64'hFFFF_FFFE_0000_0001 with the same 33-edge latency.
- A = 0, B = 32'h1234_5678, then A = 32'h8000_0000, B = 2 -> `product` = 0 after 33 edges, then 64'h1_0000_0000. Latency is unchanged for the zero operand.
- Start A=7, B=9; toggle `mul_en` and change operands every cycle during RUN -> a single `done`, `product` = 63, no extra starts observed.
- Start A=100, B=200; assert `reset` on the 10th RUN cycle -> next cycle state IDLE, `busy` = 0, `product` = 0, no `done` pulse. A new start of 6·7 then yields 42.
- `mul_en` held high with operand pairs (2,3), (4,5), (6,7) -> `done` pulses spaced 34 cycles apart with products 6, 20, 42. Each product holds until the next pulse.
